// File: rtl/idu_pkg.sv
`default_nettype none
// ============================================================================
// idu_pkg : opcodes, ALU/branch encodings and the decode->execute packet.
// Rev 1.0
// ============================================================================
package idu_pkg;

  localparam int XLEN    = 32;
  localparam int ID_EX_W = 4*XLEN + 20;

  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_reg    = 7'b0110011;
  localparam logic [6:0] c_op_fence  = 7'b0001111;
  localparam logic [6:0] c_op_system = 7'b1110011;

  localparam logic [1:0] c_mem_b = 2'd0;
  localparam logic [1:0] c_mem_h = 2'd1;
  localparam logic [1:0] c_mem_w = 2'd2;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI_PASS
  } alu_op_e;

  typedef enum logic [3:0] {
    BR_NONE, BR_JAL, BR_JALR, BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU
  } br_type_e;

  // Bit offsets of the packet fields, LSB first; they match id_ex_t below.
  localparam int ID_EX_ILLEGAL    = 0;
  localparam int ID_EX_EBREAK     = 1;
  localparam int ID_EX_WB_LINK    = 2;
  localparam int ID_EX_MEM_UNS    = 3;
  localparam int ID_EX_MEM_SIZE   = 4;
  localparam int ID_EX_MEM_WE     = 6;
  localparam int ID_EX_MEM_RE     = 7;
  localparam int ID_EX_SRC2_IMM   = 8;
  localparam int ID_EX_SRC1_PC    = 9;
  localparam int ID_EX_ALU_OP     = 10;
  localparam int ID_EX_RF_WE      = 14;
  localparam int ID_EX_RD         = 15;
  localparam int ID_EX_IMM        = 20;
  localparam int ID_EX_SRC2       = 20 + XLEN;
  localparam int ID_EX_SRC1       = 20 + 2*XLEN;
  localparam int ID_EX_PC         = 20 + 3*XLEN;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic            rf_we;
    alu_op_e         alu_op;
    logic            src1_is_pc;
    logic            src2_is_imm;
    logic            mem_re;
    logic            mem_we;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic            wb_link;
    logic            ebreak;
    logic            illegal;
  } id_ex_t;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic            rf_we;
    alu_op_e         alu_op;
    logic            src1_is_pc;
    logic            src2_is_imm;
    logic            mem_re;
    logic            mem_we;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic            wb_link;
    logic            ebreak;
    logic            illegal;
    br_type_e        br;
  } dec_t;

  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/idu_decode.sv
`default_nettype none
// ============================================================================
// idu_decode : combinational RV32I instruction -> immediate/control/branch type.
// Rev 1.0
// ============================================================================
module idu_decode
  import idu_pkg::*;
(
  input  logic [31:0] inst,
  output dec_t        dec
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

  assign w_opcode = inst[6:0];
  assign w_f3     = inst[14:12];
  assign w_f7     = inst[31:25];
  assign w_imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign w_imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign w_imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign w_imm_u  = {inst[31:12], 12'b0};
  assign w_imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    dec          = '0;
    dec.rd       = inst[11:7];
    dec.alu_op   = ALU_ADD;
    dec.br       = BR_NONE;
    dec.mem_size = c_mem_b;
    case (w_opcode)
      c_op_lui: begin
        dec.imm = w_imm_u; dec.rf_we = 1'b1; dec.src2_is_imm = 1'b1; dec.alu_op = ALU_LUI_PASS;
      end
      c_op_auipc: begin
        dec.imm = w_imm_u; dec.rf_we = 1'b1; dec.src1_is_pc = 1'b1; dec.src2_is_imm = 1'b1;
      end
      c_op_jal: begin
        dec.imm = w_imm_j; dec.rf_we = 1'b1; dec.wb_link = 1'b1; dec.br = BR_JAL;
      end
      c_op_jalr: begin
        dec.imm = w_imm_i; dec.rf_we = 1'b1; dec.wb_link = 1'b1; dec.br = BR_JALR;
        dec.illegal = (w_f3 != 3'b000);
      end
      c_op_branch: begin
        dec.imm = w_imm_b; dec.alu_op = ALU_SUB;
        case (w_f3)
          3'b000:  dec.br = BR_BEQ;
          3'b001:  dec.br = BR_BNE;
          3'b100:  dec.br = BR_BLT;
          3'b101:  dec.br = BR_BGE;
          3'b110:  dec.br = BR_BLTU;
          3'b111:  dec.br = BR_BGEU;
          default: dec.illegal = 1'b1;
        endcase
      end
      c_op_load: begin
        dec.imm = w_imm_i; dec.rf_we = 1'b1; dec.mem_re = 1'b1; dec.src2_is_imm = 1'b1;
        dec.mem_size = w_f3[1:0]; dec.mem_unsigned = w_f3[2];
        dec.illegal = !((w_f3[1:0] inside {c_mem_b, c_mem_h}) || (w_f3 == {1'b0, c_mem_w}));
      end
      c_op_store: begin
        dec.imm = w_imm_s; dec.mem_we = 1'b1; dec.src2_is_imm = 1'b1; dec.mem_size = w_f3[1:0];
        dec.illegal = w_f3[2] || !(w_f3[1:0] inside {c_mem_b, c_mem_h, c_mem_w});
      end
      c_op_imm: begin
        // Only the shift-right form uses inst[30] as a function bit; elsewhere it is immediate.
        dec.imm = w_imm_i; dec.rf_we = 1'b1; dec.src2_is_imm = 1'b1;
        dec.alu_op  = alu_from_f3(w_f3, (w_f3 == 3'b101) && inst[30]);
        dec.illegal = ((w_f3 == 3'b001) && (w_f7 != 7'b0000000)) ||
                      ((w_f3 == 3'b101) && (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000));
      end
      c_op_reg: begin
        dec.rf_we   = 1'b1;
        dec.alu_op  = alu_from_f3(w_f3, inst[30]);
        dec.illegal = !((w_f7 == 7'b0000000) ||
                        ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
      end
      c_op_fence: ;
      c_op_system: begin
        if (inst == 32'h0010_0073)      dec.ebreak  = 1'b1;
        else if (inst != 32'h0000_0073) dec.illegal = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.rf_we = 1'b0; dec.mem_re = 1'b0; dec.mem_we = 1'b0;
      dec.wb_link = 1'b0; dec.br = BR_NONE;
    end
    if (dec.rd == 5'd0) dec.rf_we = 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/idu.sv
`default_nettype none
// ============================================================================
// idu : RV32I decode stage with next-PC resolution and a one-deep WB scoreboard.
// Rev 1.0
// ============================================================================
module idu
  import idu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*DATA_WIDTH-1:0] if_to_id_bus,
  input  logic                    if_to_id_valid,
  output logic                    id_to_if_ready,
  output logic [DATA_WIDTH-1:0]   id_to_if_bus,
  output logic                    id_to_if_valid,
  input  logic                    if_to_id_ready,
  output logic [4:0]              rf_raddr1,
  output logic [4:0]              rf_raddr2,
  input  logic [DATA_WIDTH-1:0]   rf_rdata1,
  input  logic [DATA_WIDTH-1:0]   rf_rdata2,
  output logic [ID_EX_W-1:0]      id_to_ex_bus,
  output logic                    id_to_ex_valid,
  input  logic                    ex_to_id_ready,
  input  logic                    wb_to_id_done
);

  logic                  r_ir_valid, r_pc_sent, r_ex_sent, r_busy;
  logic [DATA_WIDTH-1:0] r_ir_pc, r_ir_inst;

  logic                  w_pc_fire, w_ex_fire, w_in_fire, w_done, w_taken;
  logic [DATA_WIDTH-1:0] w_seq_pc, w_br_pc, w_jalr_sum;
  dec_t                  w_dec;
  id_ex_t                w_pkt;

  idu_decode u_decode (
    .inst (r_ir_inst),
    .dec  (w_dec)
  );

  assign id_to_if_valid = r_ir_valid & ~r_busy & ~r_pc_sent;
  assign id_to_ex_valid = r_ir_valid & ~r_busy & ~r_ex_sent;
  assign w_pc_fire      = id_to_if_valid & if_to_id_ready;
  assign w_ex_fire      = id_to_ex_valid & ex_to_id_ready;
  assign w_done         = r_ir_valid & ~r_busy & (r_pc_sent | w_pc_fire) & (r_ex_sent | w_ex_fire);
  assign id_to_if_ready = ~r_ir_valid | w_done;
  assign w_in_fire      = if_to_id_valid & id_to_if_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir_valid <= 1'b0;
      r_pc_sent  <= 1'b0;
      r_ex_sent  <= 1'b0;
      r_busy     <= 1'b0;
      r_ir_pc    <= '0;
      r_ir_inst  <= '0;
    end else begin
      if (w_in_fire) begin
        r_ir_valid <= 1'b1;
        r_ir_pc    <= if_to_id_bus[2*DATA_WIDTH-1:DATA_WIDTH];
        r_ir_inst  <= if_to_id_bus[DATA_WIDTH-1:0];
        r_pc_sent  <= 1'b0;
        r_ex_sent  <= 1'b0;
      end else if (w_done) begin
        r_ir_valid <= 1'b0;
        r_pc_sent  <= 1'b0;
        r_ex_sent  <= 1'b0;
      end else begin
        if (w_pc_fire) r_pc_sent <= 1'b1;
        if (w_ex_fire) r_ex_sent <= 1'b1;
      end
      // A new issue outranks a same-cycle retire, which belongs to the older instruction.
      if (w_ex_fire)          r_busy <= 1'b1;
      else if (wb_to_id_done) r_busy <= 1'b0;
    end
  end

  assign rf_raddr1  = r_ir_inst[19:15];
  assign rf_raddr2  = r_ir_inst[24:20];
  assign w_seq_pc   = r_ir_pc + 32'd4;
  assign w_br_pc    = r_ir_pc + w_dec.imm;
  assign w_jalr_sum = rf_rdata1 + w_dec.imm;

  always_comb begin
    case (w_dec.br)
      BR_BEQ:  w_taken = (rf_rdata1 == rf_rdata2);
      BR_BNE:  w_taken = (rf_rdata1 != rf_rdata2);
      BR_BLT:  w_taken = ($signed(rf_rdata1) <  $signed(rf_rdata2));
      BR_BGE:  w_taken = ($signed(rf_rdata1) >= $signed(rf_rdata2));
      BR_BLTU: w_taken = (rf_rdata1 <  rf_rdata2);
      BR_BGEU: w_taken = (rf_rdata1 >= rf_rdata2);
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    case (w_dec.br)
      BR_JAL:  id_to_if_bus = w_br_pc;
      BR_JALR: id_to_if_bus = {w_jalr_sum[DATA_WIDTH-1:1], 1'b0};
      default: id_to_if_bus = w_taken ? w_br_pc : w_seq_pc;
    endcase
  end

  always_comb begin
    w_pkt              = '0;
    w_pkt.pc           = r_ir_pc;
    w_pkt.src1         = rf_rdata1;
    w_pkt.src2         = rf_rdata2;
    w_pkt.imm          = w_dec.imm;
    w_pkt.rd           = w_dec.rd;
    w_pkt.rf_we        = w_dec.rf_we;
    w_pkt.alu_op       = w_dec.alu_op;
    w_pkt.src1_is_pc   = w_dec.src1_is_pc;
    w_pkt.src2_is_imm  = w_dec.src2_is_imm;
    w_pkt.mem_re       = w_dec.mem_re;
    w_pkt.mem_we       = w_dec.mem_we;
    w_pkt.mem_size     = w_dec.mem_size;
    w_pkt.mem_unsigned = w_dec.mem_unsigned;
    w_pkt.wb_link      = w_dec.wb_link;
    w_pkt.ebreak       = w_dec.ebreak;
    w_pkt.illegal      = w_dec.illegal;
  end

  assign id_to_ex_bus = w_pkt;

endmodule
`default_nettype wire

// File: tb/tb_idu.sv
`default_nettype none
// ============================================================================
// tb_idu : directed self-checking bench for the idu decode stage.
// Rev 1.0
// ============================================================================
module tb_idu;
  import idu_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic [63:0]        if_to_id_bus;
  logic               if_to_id_valid, id_to_if_ready;
  logic [31:0]        id_to_if_bus;
  logic               id_to_if_valid, if_to_id_ready;
  logic [4:0]         rf_raddr1, rf_raddr2;
  logic [31:0]        rf_rdata1, rf_rdata2;
  logic [ID_EX_W-1:0] id_to_ex_bus;
  logic               id_to_ex_valid, ex_to_id_ready, wb_to_id_done;

  int checks   = 0;
  int failures = 0;

  idu #(.DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_to_id_bus   (if_to_id_bus),
    .if_to_id_valid (if_to_id_valid),
    .id_to_if_ready (id_to_if_ready),
    .id_to_if_bus   (id_to_if_bus),
    .id_to_if_valid (id_to_if_valid),
    .if_to_id_ready (if_to_id_ready),
    .rf_raddr1      (rf_raddr1),
    .rf_raddr2      (rf_raddr2),
    .rf_rdata1      (rf_rdata1),
    .rf_rdata2      (rf_rdata2),
    .id_to_ex_bus   (id_to_ex_bus),
    .id_to_ex_valid (id_to_ex_valid),
    .ex_to_id_ready (ex_to_id_ready),
    .wb_to_id_done  (wb_to_id_done)
  );

  always #5 clk = ~clk;

  logic [31:0] f_pc, f_imm, f_src1;
  logic [4:0]  f_rd;
  logic [3:0]  f_alu;
  logic        f_rf_we, f_wb_link, f_illegal, f_mem_we;
  assign f_pc      = id_to_ex_bus[ID_EX_PC   +: XLEN];
  assign f_src1    = id_to_ex_bus[ID_EX_SRC1 +: XLEN];
  assign f_imm     = id_to_ex_bus[ID_EX_IMM  +: XLEN];
  assign f_rd      = id_to_ex_bus[ID_EX_RD   +: 5];
  assign f_alu     = id_to_ex_bus[ID_EX_ALU_OP +: 4];
  assign f_rf_we   = id_to_ex_bus[ID_EX_RF_WE];
  assign f_wb_link = id_to_ex_bus[ID_EX_WB_LINK];
  assign f_illegal = id_to_ex_bus[ID_EX_ILLEGAL];
  assign f_mem_we  = id_to_ex_bus[ID_EX_MEM_WE];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one packet upstream; it is captured at the next edge (ir must be empty).
  task automatic load(input logic [31:0] pc, input logic [31:0] inst);
    if_to_id_bus   = {pc, inst};
    if_to_id_valid = 1'b1;
    tick();
    if_to_id_valid = 1'b0;
  endtask

  task automatic wb_pulse();
    wb_to_id_done = 1'b1;
    tick();
    wb_to_id_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_to_id_bus = '0; if_to_id_valid = 1'b0; if_to_id_ready = 1'b0;
    rf_rdata1 = '0; rf_rdata2 = '0; ex_to_id_ready = 1'b0; wb_to_id_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_if_valid", id_to_if_valid, 0);
    check("rst_ex_valid", id_to_ex_valid, 0);
    check("rst_ready", id_to_if_ready, 1);
    rst = 1'b0;

    // addi x1,x0,5 with both sides ready: issues and retires one cycle after capture
    if_to_id_ready = 1'b1; ex_to_id_ready = 1'b1;
    load(32'h8000_0000, 32'h0050_0093);
    @(negedge clk);
    check("addi_if_valid", id_to_if_valid, 1);
    check("addi_ex_valid", id_to_ex_valid, 1);
    check("addi_imm", f_imm, 5);
    check("addi_rd", f_rd, 1);
    check("addi_rf_we", f_rf_we, 1);
    check("addi_alu", f_alu, ALU_ADD);
    check("addi_dnpc", id_to_if_bus, 32'h8000_0004);
    check("addi_ready_retire", id_to_if_ready, 1);
    tick();
    @(negedge clk);
    check("addi_after_if_valid", id_to_if_valid, 0);
    check("addi_after_ex_valid", id_to_ex_valid, 0);
    wb_pulse();

    // jal x1,+8
    load(32'h8000_0010, 32'h0080_00EF);
    @(negedge clk);
    check("jal_dnpc", id_to_if_bus, 32'h8000_0018);
    check("jal_wb_link", f_wb_link, 1);
    check("jal_rd", f_rd, 1);
    check("jal_rf_we", f_rf_we, 1);
    tick(); wb_pulse();

    // jalr x1,4(x5): low bit of the target is cleared
    rf_rdata1 = 32'h0000_1001;
    load(32'h8000_0014, 32'h0042_80E7);
    @(negedge clk);
    check("jalr_raddr1", rf_raddr1, 5);
    check("jalr_src1", f_src1, 32'h0000_1001);
    check("jalr_dnpc", id_to_if_bus, 32'h0000_1004);
    tick(); wb_pulse();

    // beq x1,x2,-4: taken then not taken
    rf_rdata1 = 32'd7; rf_rdata2 = 32'd7;
    load(32'h8000_0020, 32'hFE20_8EE3);
    @(negedge clk);
    check("beq_raddr1", rf_raddr1, 1);
    check("beq_raddr2", rf_raddr2, 2);
    check("beq_rf_we", f_rf_we, 0);
    check("beq_taken_dnpc", id_to_if_bus, 32'h8000_001C);
    #1 rf_rdata2 = 32'd8;
    #1 check("beq_nt_dnpc", id_to_if_bus, 32'h8000_0024);
    tick(); wb_pulse();

    // blt is signed (-1 < 1 taken), bltu is unsigned (0xFFFFFFFF < 1 not taken)
    rf_rdata1 = 32'hFFFF_FFFF; rf_rdata2 = 32'd1;
    load(32'h8000_0040, 32'h0020_C463);
    @(negedge clk);
    check("blt_dnpc", id_to_if_bus, 32'h8000_0048);
    tick(); wb_pulse();
    load(32'h8000_0040, 32'h0020_E463);
    @(negedge clk);
    check("bltu_dnpc", id_to_if_bus, 32'h8000_0044);
    tick(); wb_pulse();

    // unknown opcode at the top of the address space: still issued, pc+4 wraps to 0
    load(32'hFFFF_FFFC, 32'hFFFF_FFFF);
    @(negedge clk);
    check("ill_ex_valid", id_to_ex_valid, 1);
    check("ill_flag", f_illegal, 1);
    check("ill_rf_we", f_rf_we, 0);
    check("ill_mem_we", f_mem_we, 0);
    check("ill_dnpc_wrap", id_to_if_bus, 32'h0000_0000);
    tick(); wb_pulse();

    // split handshake: fetch takes dnpc at once, execute stalls for 3 cycles
    ex_to_id_ready = 1'b0;
    load(32'h8000_0030, 32'h0030_0113);
    @(negedge clk);
    check("split_c1_if_valid", id_to_if_valid, 1);
    check("split_c1_ex_valid", id_to_ex_valid, 1);
    check("split_c1_ready", id_to_if_ready, 0);
    for (int c = 2; c <= 3; c++) begin
      tick();
      @(negedge clk);
      check("split_if_valid_dropped", id_to_if_valid, 0);
      check("split_ex_valid_held", id_to_ex_valid, 1);
      check("split_imm_stable", f_imm, 3);
      check("split_pc_stable", f_pc, 32'h8000_0030);
      check("split_ready_low", id_to_if_ready, 0);
    end
    // execute accepts while the next instruction is offered back-to-back
    ex_to_id_ready = 1'b1;
    if_to_id_bus = {32'h8000_0034, 32'h0070_0193};
    if_to_id_valid = 1'b1;
    #1 check("split_ready_on_ex_fire", id_to_if_ready, 1);
    tick();
    if_to_id_valid = 1'b0;

    // scoreboard: second instruction waits for writeback of the first
    @(negedge clk);
    check("sb_busy_if_valid", id_to_if_valid, 0);
    check("sb_busy_ex_valid", id_to_ex_valid, 0);
    check("sb_busy_ready", id_to_if_ready, 0);
    tick();
    @(negedge clk);
    check("sb_still_busy", id_to_ex_valid, 0);
    wb_pulse();
    @(negedge clk);
    check("sb_issue_if_valid", id_to_if_valid, 1);
    check("sb_issue_ex_valid", id_to_ex_valid, 1);
    check("sb_issue_imm", f_imm, 7);
    check("sb_issue_rd", f_rd, 3);
    // wb_to_id_done coincides with this ex_fire: busy must remain set
    wb_to_id_done = 1'b1;
    tick();
    wb_to_id_done = 1'b0;
    load(32'h8000_0038, 32'h0010_0213);
    @(negedge clk);
    check("sb_setwins_if_valid", id_to_if_valid, 0);
    check("sb_setwins_ex_valid", id_to_ex_valid, 0);
    wb_pulse();
    @(negedge clk);
    check("sb_release_ex_valid", id_to_ex_valid, 1);
    check("sb_release_pc", f_pc, 32'h8000_0038);
    tick(); wb_pulse();

    // reset while a packet waits on execute
    ex_to_id_ready = 1'b0; if_to_id_ready = 1'b0;
    load(32'h8000_0050, 32'h0050_0093);
    @(negedge clk);
    check("rstA_pre_ex_valid", id_to_ex_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("rstA_if_valid", id_to_if_valid, 0);
    check("rstA_ex_valid", id_to_ex_valid, 0);
    check("rstA_ready", id_to_if_ready, 1);
    tick();
    rst = 1'b0; ex_to_id_ready = 1'b1; if_to_id_ready = 1'b1;
    @(negedge clk);
    check("rstA_no_stale_ex", id_to_ex_valid, 0);
    check("rstA_no_stale_if", id_to_if_valid, 0);

    // reset while busy with a second instruction held
    load(32'h8000_0060, 32'h0050_0093);
    tick();
    load(32'h8000_0064, 32'h0050_0093);
    @(negedge clk);
    check("rstB_pre_ready", id_to_if_ready, 0);
    #1 rst = 1'b1;
    #1;
    check("rstB_ready", id_to_if_ready, 1);
    check("rstB_ex_valid", id_to_ex_valid, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rstB_no_stale", id_to_ex_valid, 0);
    load(32'h8000_0070, 32'h0050_0093);
    @(negedge clk);
    check("rstB_busy_cleared", id_to_ex_valid, 1);
    check("rstB_dnpc", id_to_if_bus, 32'h8000_0074);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/idu.md
Name: idu

Overview:
- Decode stage directly downstream of the instruction-fetch stage.
- Accepts {pc, inst} over a valid/ready bus and decodes RV32I.
- Reads the register file through combinational read ports, resolves the next PC (sequential, jal, jalr, branches) and returns it upstream as dnpc.
- Issues a decoded control/operand packet to the execute stage.
- Allows one instruction in flight beyond decode; a scoreboard waits for writeback before issuing the next one.

Parameters:
- DATA_WIDTH, 32, datapath/PC width. Only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- if_to_id_bus  in  2*DATA_WIDTH  {pc, inst}
- if_to_id_valid  in  1  upstream packet valid
- id_to_if_ready  out  1  idu can take a new packet
- id_to_if_bus  out  DATA_WIDTH  dnpc
- id_to_if_valid  out  1  dnpc valid
- if_to_id_ready  in  1  fetch accepts dnpc
- rf_raddr1, rf_raddr2  out  5  rs1/rs2 addresses; driven from held inst
- rf_rdata1, rf_rdata2  in  DATA_WIDTH  combinational read data; x0 reads 0
- id_to_ex_bus  out  ID_EX_W  decoded packet (see package)
- id_to_ex_valid  out  1  packet valid
- ex_to_id_ready  in  1  execute accepts packet
- wb_to_id_done  in  1  single-cycle pulse when the in-flight instruction retires

Behaviour:
- Registers:
  - ir_valid, ir_pc, ir_inst: the held instruction.
  - pc_sent, ex_sent: handshake-completed flags.
  - busy: scoreboard, one instruction between EX issue and WB.
- Reset (async, rst=1):
  - ir_valid=0, pc_sent=0, ex_sent=0, busy=0.
  - Outputs: id_to_if_valid=0, id_to_ex_valid=0, id_to_if_ready=1, buses don't-care.
  - Asserting rst mid-handshake drops everything; no partial packet is issued after release.
- Fire definitions:
  - pc_fire = id_to_if_valid & if_to_id_ready
  - ex_fire = id_to_ex_valid & ex_to_id_ready
  - in_fire = if_to_id_valid & id_to_if_ready
- Issue gating:
  - id_to_if_valid = ir_valid & ~busy & ~pc_sent
  - id_to_ex_valid = ir_valid & ~busy & ~ex_sent
  - Both may assert in the same cycle. Latency from in_fire to valids is 1 cycle when not busy.
- Retire from ID: done = ir_valid & ~busy & (pc_sent|pc_fire) & (ex_sent|ex_fire).
  - On done, clear ir_valid, pc_sent and ex_sent, unless in_fire in the same cycle loads the next instruction (reload flags to 0).
- id_to_if_ready = ~ir_valid | done. This allows back-to-back throughput.
- Partial completion: a fire on one side sets its sent flag. That valid drops next cycle. The other side stays valid with a stable payload.
- Scoreboard:
  - ex_fire sets busy; wb_to_id_done clears it.
  - If both occur in the same cycle, busy=1 (set wins; the done refers to the older instruction).
  - wb_to_id_done while busy=0 is ignored.
- Stability: while ir_valid & ~busy the register file cannot change, because busy guards the only writer. Payloads are therefore stable under valid.
- dnpc:
  - JAL: pc+immJ.
  - JALR: (rs1+immI) & ~1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: pc+immB if taken, else pc+4. Signed compares for BLT/BGE, unsigned for BLTU/BGEU.
  - All other instructions: pc+4.
  - All adds are modulo 2^DATA_WIDTH (wrap-around from 0xFFFFFFFC gives 0).
- id_to_ex_bus fields:
  - pc, src1=rf_rdata1, src2=rf_rdata2, imm (sign-extended I/S/B/U/J as applicable).
  - rd, rf_we (forced 0 when rd=0), alu_op, src1_is_pc, src2_is_imm.
  - mem_re, mem_we, mem_size (0=B, 1=H, 2=W), mem_unsigned.
  - wb_link (write pc+4), ebreak, illegal.
- Unknown opcode/funct: illegal=1, rf_we=0, mem_re=mem_we=0, dnpc=pc+4. The packet is still issued.

Decomposition:
- Package idu_pkg:
  - Opcode constants.
  - alu_op encoding (4 bits: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, LUI_PASS).
  - mem_size codes.
  - ID_EX field offsets and ID_EX_W = 4*DATA_WIDTH+20.
- Sub-module idu_decode: purely combinational inst→{imm, control fields, branch type}.
- The top level holds the handshake/scoreboard registers, the branch compare and the dnpc adder.

Test Plan:
- Reset mid-operation: rst pulsed while id_to_ex_valid=1 and busy=1 → both valids 0 asynchronously, id_to_if_ready=1, no stale issue after release.
- addi x1,x0,5 (0x00500093) at pc 0x80000000, both readies 1 → one cycle later both valids=1, imm=5, rd=1, rf_we=1, alu_op=ADD, dnpc=0x80000004; retired in that cycle.
- jal x1,+8 (0x008000EF) at 0x80000010 → dnpc=0x80000018, wb_link=1, rd=1, rf_we=1.
- beq x1,x2,-4 (0xFE208EE3) at 0x80000020:
  - rdata1=rdata2=7 → dnpc=0x8000001C.
  - rdata1=7, rdata2=8 → dnpc=0x80000024.
- Split handshake: if_to_id_ready=1, ex_to_id_ready=0 for 3 cycles → id_to_if_valid high 1 cycle only, id_to_ex_bus stable, id_to_if_ready=0 until ex_fire, then retire.
- Scoreboard: the second instruction arrives right after the first's ex_fire → valids stay 0 until wb_to_id_done. Then issue occurs. A same-cycle wb_to_id_done and ex_fire leaves busy=1.
